// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction through 3-5 states, stalling the memory states
// on MemReady. IRWrite/PCWrite in FETCH and IllegalOp in DECODE are Mealy
// strobes; everything else is decoded from the current state.
//
// state  | code | meaning
// FETCH  |  0   | read instruction at PC, PC+4 on ready
// DECODE |  1   | register read, branch target into ALUOut
// MEMADR |  2   | compute load/store address
// MEMRD  |  3   | load data read, wait for ready
// MEMWB  |  4   | write MDR to rt
// MEMWR  |  5   | store write, wait for ready
// EXEC   |  6   | R-type ALU operation
// RWB    |  7   | write ALUOut to rd
// BEQ    |  8   | branch if equal
// BNE    |  9   | branch if not equal
// IEXEC  | 10   | immediate ALU operation
// IWB    | 11   | write ALUOut to rt
// JUMP   | 12   | load jump target into PC
module multicycle_control_unit #(
    parameter int OP_WIDTH      = 6,
    parameter int ALUOP_WIDTH   = 3,
    parameter bit ENABLE_IEXT   = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_WIDTH-1:0]    OpCode,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   PCWriteCondNot,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSrc,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [3:0]             State,
    output logic                   IllegalOp
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
        BEQ    = 4'd8,  BNE    = 4'd9,  IEXEC  = 4'd10, IWB   = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUBEQ = 3'b001;
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLT   = 3'b100;
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = 3'b101;
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUBNE = 3'b110;

    state_t                   state;
    logic [ALUOP_WIDTH-1:0]   immAluOp;
    state_t                   decodeNext;
    logic [ALUOP_WIDTH-1:0]   decodeImmOp;
    logic                     decodeIllegal;
    logic                     memOk;

    // Without the handshake every memory access completes in one cycle.
    assign memOk = MEM_HANDSHAKE ? MemReady : 1'b1;
    assign State = state;

    // Opcode dispatch out of DECODE; the immediate ALU op is latched so that
    // IEXEC and IWB do not depend on OpCode after DECODE.
    always_comb begin
        decodeNext    = FETCH;
        decodeImmOp   = ALU_ADD;
        decodeIllegal = 1'b0;
        case (OpCode)
            OP_LW, OP_SW: decodeNext = MEMADR;
            OP_RTYPE:     decodeNext = EXEC;
            OP_BEQ:       decodeNext = BEQ;
            OP_J:         decodeNext = JUMP;
            OP_ADDI:      decodeNext = IEXEC;
            OP_BNE: begin
                if (ENABLE_IEXT) decodeNext = BNE;
                else             decodeIllegal = 1'b1;
            end
            OP_ANDI: begin
                decodeImmOp = ALU_AND;
                if (ENABLE_IEXT) decodeNext = IEXEC;
                else             decodeIllegal = 1'b1;
            end
            OP_SLTI: begin
                decodeImmOp = ALU_SLT;
                if (ENABLE_IEXT) decodeNext = IEXEC;
                else             decodeIllegal = 1'b1;
            end
            OP_ORI: begin
                decodeImmOp = ALU_OR;
                if (ENABLE_IEXT) decodeNext = IEXEC;
                else             decodeIllegal = 1'b1;
            end
            default:      decodeIllegal = 1'b1;
        endcase
    end

    // State sequencing; unreachable codes fall back to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            immAluOp <= ALU_ADD;
        end else begin
            case (state)
                FETCH:   if (memOk) state <= DECODE;
                DECODE: begin
                    state    <= decodeNext;
                    immAluOp <= decodeImmOp;
                end
                MEMADR:  state <= (OpCode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (memOk) state <= MEMWB;
                MEMWR:   if (memOk) state <= FETCH;
                EXEC:    state <= RWB;
                IEXEC:   state <= IWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Control outputs; forced low during reset so nothing fires after rst rises.
    always_comb begin
        PCWrite        = 1'b0;
        PCWriteCond    = 1'b0;
        PCWriteCondNot = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        MemtoReg       = 1'b0;
        RegDst         = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        PCSrc          = 2'b00;
        ALUOp          = ALU_ADD;
        IllegalOp      = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = memOk;
                    PCWrite = memOk;
                end
                DECODE: begin
                    ALUSrcB   = 2'b11;
                    IllegalOp = decodeIllegal;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUBEQ;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'b01;
                end
                BNE: begin
                    ALUSrcA        = 1'b1;
                    ALUOp          = ALU_SUBNE;
                    PCWriteCondNot = 1'b1;
                    PCSrc          = 2'b01;
                end
                IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = immAluOp;
                end
                IWB: begin
                    RegWrite = 1'b1;
                    ALUOp    = immAluOp;
                end
                JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (extended opcodes on/off)
// checked every cycle against an instruction-path model, plus literal
// latency/strobe-count expectations.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcw, pcwc, pcwcn, iord, mrd, mwr, irw, m2r, rdst, rw, srcA;
        logic [1:0] srcB, pcsrc;
        logic [2:0] aluop;
        logic [3:0] st;
        logic       ill;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opCode = 6'b0;
    logic memReady = 1'b0;

    logic pcwA, pcwcA, pcwcnA, iordA, mrdA, mwrA, irwA, m2rA, rdstA, rwA, srcAA, illA;
    logic [1:0] srcBA, pcsrcA;
    logic [2:0] aluopA;
    logic [3:0] stA;
    logic pcwB, pcwcB, pcwcnB, iordB, mrdB, mwrB, irwB, m2rB, rdstB, rwB, srcAB, illB;
    logic [1:0] srcBB, pcsrcB;
    logic [2:0] aluopB;
    logic [3:0] stB;

    out_t actA, actB;
    assign actA = {pcwA, pcwcA, pcwcnA, iordA, mrdA, mwrA, irwA, m2rA, rdstA, rwA, srcAA,
                   srcBA, pcsrcA, aluopA, stA, illA};
    assign actB = {pcwB, pcwcB, pcwcnB, iordB, mrdB, mwrB, irwB, m2rB, rdstB, rwB, srcAB,
                   srcBB, pcsrcB, aluopB, stB, illB};

    always #5 clk = ~clk;

    multicycle_control_unit #(.ENABLE_IEXT(1'b1)) dutA (
        .clk(clk), .rst(rst), .OpCode(opCode), .MemReady(memReady),
        .PCWrite(pcwA), .PCWriteCond(pcwcA), .PCWriteCondNot(pcwcnA), .IorD(iordA),
        .MemRead(mrdA), .MemWrite(mwrA), .IRWrite(irwA), .MemtoReg(m2rA),
        .RegDst(rdstA), .RegWrite(rwA), .ALUSrcA(srcAA), .ALUSrcB(srcBA),
        .PCSrc(pcsrcA), .ALUOp(aluopA), .State(stA), .IllegalOp(illA));

    multicycle_control_unit #(.ENABLE_IEXT(1'b0)) dutB (
        .clk(clk), .rst(rst), .OpCode(opCode), .MemReady(memReady),
        .PCWrite(pcwB), .PCWriteCond(pcwcB), .PCWriteCondNot(pcwcnB), .IorD(iordB),
        .MemRead(mrdB), .MemWrite(mwrB), .IRWrite(irwB), .MemtoReg(m2rB),
        .RegDst(rdstB), .RegWrite(rwB), .ALUSrcA(srcAB), .ALUSrcB(srcBB),
        .PCSrc(pcsrcB), .ALUOp(aluopB), .State(stB), .IllegalOp(illB));

    int nAssert = 0;
    int nFail = 0;

    out_t expA[$];
    out_t expB[$];
    out_t mdlA[64];
    out_t mdlB[64];

    int obsCyc, obsRet, obsMemWr, obsIrw, obsIllA, obsIllB, obsRwB;
    logic [3:0] prevA;

    // Outputs expected in one cycle of a given step of an instruction's path.
    function automatic out_t stepOut(input int ph, input bit rdy, input logic [2:0] iop,
                                     input bit ill);
        out_t o;
        o = '0;
        o.st = 4'(ph);
        case (ph)
            0:  begin o.mrd = 1; o.srcB = 2'b01; o.irw = rdy; o.pcw = rdy; end
            1:  begin o.srcB = 2'b11; o.ill = ill; end
            2:  begin o.srcA = 1; o.srcB = 2'b10; end
            3:  begin o.mrd = 1; o.iord = 1; end
            4:  begin o.rw = 1; o.m2r = 1; end
            5:  begin o.mwr = 1; o.iord = 1; end
            6:  begin o.srcA = 1; o.aluop = 3'b010; end
            7:  begin o.rw = 1; o.rdst = 1; end
            8:  begin o.srcA = 1; o.pcwc = 1; o.pcsrc = 2'b01; o.aluop = 3'b001; end
            9:  begin o.srcA = 1; o.pcwcn = 1; o.pcsrc = 2'b01; o.aluop = 3'b110; end
            10: begin o.srcA = 1; o.srcB = 2'b10; o.aluop = iop; end
            11: begin o.rw = 1; o.aluop = iop; end
            12: begin o.pcw = 1; o.pcsrc = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    // Walk the instruction's step list, holding on memory steps until ready,
    // and restarting the same instruction after the last step.
    task automatic buildExp(input bit iext, input logic [5:0] op, input int n,
                            input logic [63:0] rdy);
        int path[$];
        int idx;
        int ph;
        bit ill;
        logic [2:0] iop;
        out_t o;
        iop = 3'b000;
        case (op)
            6'b100011: path = {0, 1, 2, 3, 4};
            6'b101011: path = {0, 1, 2, 5};
            6'b000000: path = {0, 1, 6, 7};
            6'b000100: path = {0, 1, 8};
            6'b000010: path = {0, 1, 12};
            6'b001000: path = {0, 1, 10, 11};
            6'b000101: if (iext) path = {0, 1, 9}; else path = {0, 1};
            6'b001100: begin iop = 3'b011; if (iext) path = {0, 1, 10, 11}; else path = {0, 1}; end
            6'b001010: begin iop = 3'b100; if (iext) path = {0, 1, 10, 11}; else path = {0, 1}; end
            6'b001101: begin iop = 3'b101; if (iext) path = {0, 1, 10, 11}; else path = {0, 1}; end
            default:   path = {0, 1};
        endcase
        ill = (path.size() == 2);
        idx = 0;
        for (int c = 0; c < n; c++) begin
            ph = path[idx];
            o = stepOut(ph, rdy[c], iop, ill);
            if (iext) mdlA[c] = o; else mdlB[c] = o;
            if (!((ph == 0 || ph == 3 || ph == 5) && !rdy[c]))
                idx = (idx + 1) % path.size();
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        out_t e;
        if (expA.size() > 0) begin
            e = expA.pop_front();
            nAssert++;
            if (actA !== e) begin
                nFail++;
                $display("FAIL cycleA[%0d] op=%b got %h required %h", obsCyc, opCode, actA, e);
            end
            if (obsRet < 0 && actA.st == 4'd0 && prevA != 4'd0) obsRet = obsCyc;
            prevA = actA.st;
            obsMemWr += int'(actA.mwr);
            obsIrw   += int'(actA.irw);
            obsIllA  += int'(actA.ill);
            obsCyc++;
        end
        if (expB.size() > 0) begin
            e = expB.pop_front();
            nAssert++;
            if (actB !== e) begin
                nFail++;
                $display("FAIL cycleB[%0d] op=%b got %h required %h", obsCyc - 1, opCode, actB, e);
            end
            obsIllB += int'(actB.ill);
            obsRwB  += int'(actB.rw);
        end
    end

    task automatic checkEq(input string name, input int act, input int req);
        nAssert++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    // Reset, then run n cycles of one opcode with the given MemReady pattern.
    task automatic runTest(input logic [5:0] op, input int n, input logic [63:0] rdy);
        buildExp(1'b1, op, n, rdy);
        buildExp(1'b0, op, n, rdy);
        rst = 1'b1;
        memReady = 1'b0;
        opCode = op;
        @(posedge clk);
        #1;
        checkEq("resetOutputsA", int'(actA), 0);
        checkEq("resetOutputsB", int'(actB), 0);
        obsCyc = 0; obsRet = -1; obsMemWr = 0; obsIrw = 0;
        obsIllA = 0; obsIllB = 0; obsRwB = 0; prevA = 4'd0;
        rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            memReady = rdy[c];
            expA.push_back(mdlA[c]);
            expB.push_back(mdlB[c]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // lw, ready throughout: 5 cycles, back in FETCH at cycle 5
        runTest(6'b100011, 6, 64'h1F);
        checkEq("lwLatency", obsRet, 5);

        // sw: 3 FETCH stalls, 2 MEMWR stalls -> 9 cycles
        runTest(6'b101011, 10, 64'h108);
        checkEq("swStallLatency", obsRet, 9);
        checkEq("swMemWriteCycles", obsMemWr, 3);
        checkEq("swIRWritePulses", obsIrw, 1);

        runTest(6'b000100, 4, 64'h7);
        checkEq("beqLatency", obsRet, 3);

        runTest(6'b000101, 4, 64'h1);
        checkEq("bneLatency", obsRet, 3);
        checkEq("bneIllegalNoIext", obsIllB, 1);

        runTest(6'b000010, 4, 64'h7);
        checkEq("jLatency", obsRet, 3);

        runTest(6'b000000, 5, 64'hF);
        checkEq("rtypeLatency", obsRet, 4);

        runTest(6'b001101, 5, 64'hF);
        checkEq("oriLatency", obsRet, 4);

        runTest(6'b001000, 6, 64'h3);
        checkEq("addiLatency", obsRet, 4);

        runTest(6'b001010, 5, 64'h1);
        checkEq("sltiLatency", obsRet, 4);

        runTest(6'b001100, 5, 64'h1);
        checkEq("andiLatency", obsRet, 4);
        checkEq("andiIllegalNoIext", obsIllB, 1);
        checkEq("andiRegWriteNoIext", obsRwB, 0);
        checkEq("andiIllegalIext", obsIllA, 0);

        runTest(6'b111111, 4, 64'h1);
        checkEq("illegalPulseA", obsIllA, 1);
        checkEq("illegalPulseB", obsIllB, 1);

        // Reset while waiting in MEMWR: outputs drop before the next edge
        runTest(6'b101011, 5, 64'h1);
        checkEq("memWrBeforeReset", int'(mwrA), 1);
        checkEq("stateBeforeReset", int'(stA), 5);
        #2;
        rst = 1'b1;
        #1;
        checkEq("memWrAsyncReset", int'(mwrA), 0);
        checkEq("stateAsyncReset", int'(stA), 0);
        checkEq("memReadAsyncReset", int'(mrdA), 0);

        // Fetch restarts cleanly afterwards
        runTest(6'b100011, 6, 64'h1F);
        checkEq("lwAfterResetLatency", obsRet, 5);

        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        nFail++;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM controller for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder.
- Sequences each instruction over 3–5 states and waits on a memory-ready handshake.
- Keeps the existing 3-bit ALUOp encoding.
- Extended opcode set (andi/slti/ori/bne) and the memory handshake are parameter-selectable.

Parameters:
- OP_WIDTH, 6, opcode width (fixed MIPS encoding; other values unsupported).
- ALUOP_WIDTH, 3, ALUOp width, matching the existing ALU control.
- ENABLE_IEXT, 1, 1 = andi/slti/ori/bne legal; 0 = these opcodes are illegal.
- MEM_HANDSHAKE, 1, 1 = memory states wait for MemReady; 0 = MemReady ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- OpCode  input  OP_WIDTH  instruction[31:26]; taken from the instruction register, valid from DECODE onward.
- MemReady  input  1  memory access completes this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if Zero (beq).
- PCWriteCondNot  output  1  PC load if !Zero (bne).
- IorD  output  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-back data select: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  1 = rd, 0 = rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = A.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  ALUOP_WIDTH  000 add, 001 sub (beq), 010 funct, 011 and, 100 slt, 101 or, 110 sub (bne).
- State  output  4  current state code, for debug.
- IllegalOp  output  1  one-cycle pulse in DECODE on an unsupported opcode.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is asynchronous, active-high.
- Reset value: while rst=1, state = FETCH (code 0) and every output is 0, including MemRead; State reads 0.
- First fetch: begins on the first clk edge after rst deasserts.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, BNE=9, IEXEC=10, IWB=11, JUMP=12. Codes 13–15 are unreachable and return to FETCH on the next edge.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00.
  - IRWrite and PCWrite are 1 only in the cycle MemReady=1 (Mealy gating).
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by OpCode:
  - 100011 (lw) and 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BEQ.
  - 000101 (bne) -> BNE.
  - 001000 (addi), 001100 (andi), 001010 (slti), 001101 (ori) -> IEXEC.
  - 000010 (j) -> JUMP.
  - Any other opcode -> FETCH with IllegalOp=1 for that cycle.
  - With ENABLE_IEXT=0, andi/slti/ori/bne take the illegal path.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then FETCH. MemWrite stays high throughout the wait.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Then RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSrc=01. Then FETCH.
- BNE: as BEQ, but ALUOp=110 and PCWriteCondNot=1 instead of PCWriteCond. Then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp = 000 addi, 011 andi, 100 slt, 101 ori. Then IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. ALUOp holds the IEXEC value. Then FETCH.
- JUMP: PCWrite=1, PCSrc=10. Then FETCH.
- Unlisted outputs are 0 in every state.
- Latency with MemReady held at 1: lw 5 cycles; sw, R-type and I-ALU 4 cycles; beq, bne and j 3 cycles. Each extra MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- OpCode is sampled only in DECODE and MEMADR; it may change at any other time without effect.
- MemReady outside FETCH/MEMRD/MEMWR is ignored.
- With MEM_HANDSHAKE=0, every memory state lasts exactly one cycle.
- Reset mid-instruction (including mid-wait): outputs drop to 0 immediately, without waiting for a clock edge. No partial RegWrite/MemWrite/PCWrite occurs after rst rises.
- PCWrite and the two conditional PC strobes are mutually exclusive in every state.

Test Plan:
- Reset: rst pulsed high mid-MEMWR with MemWrite=1 -> MemWrite=0 and State=0 within the same cycle, before the next clk edge; fetch restarts after release.
- lw, MemReady tied 1: State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; exactly 5 cycles.
- Memory stalls: sw with MemReady=0 for 3 cycles in FETCH and 2 cycles in MEMWR -> IRWrite pulses once, at ready; MemWrite high for 3 cycles; total 9 cycles.
- Branch and jump: beq -> PCWriteCond=1 with ALUOp=001 in state 8. bne -> PCWriteCondNot=1 with ALUOp=110 in state 9. j -> PCWrite=1 with PCSrc=10 in state 12. Each takes 3 cycles.
- Immediate ALU: ori (001101) -> ALUOp=101 and ALUSrcB=10 in state 10; RegWrite=1 and RegDst=0 in state 11.
- Illegal opcodes: 111111 -> IllegalOp=1 for one cycle, then FETCH. With ENABLE_IEXT=0, andi (001100) behaves the same way and RegWrite never asserts.
